draw_bar: RTL
=============

Name: draw_bar

Overview:
Parametrised successor to the boss HP bar drawer. It renders a full horizontal gauge into the VGA adapter's pixel-write port. Columns up to the latched value are drawn in a fill colour and the remainder in an empty colour, so a shrinking value erases stale pixels with no separate clear pass. Instantiated once per gauge (boss HP, player HP, charge meter) and arbitrated upstream by the frame-draw controller through a start/done level handshake.

Parameters:
X0, 128, left screen column of the bar (0..159)
Y0, 6, top screen row of the bar (0..119)
BAR_H, 4, bar height in rows (>=1)
MAX_LEN, 31, bar length in columns; X0+MAX_LEN-1 <= 159
VAL_W, 5, width of value input
COLOR_W, 3, colour width of the VGA adapter
FILL_COLOR, 3'b100, colour of filled columns
EMPTY_COLOR, 3'b000, colour of unfilled columns
DIR, 0, 0 = fill grows from X0 rightwards; 1 = fill anchored at right end, grows leftwards

Ports:
clk  in  1  system clock; all state changes on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  level request; draw begins on a rising-edge sample while idle
value  in  VAL_W  gauge value; sampled only at draw start
busy  out  1  high in DRAW state
done  out  1  high from the end of draw until start is sampled low
drawEn  out  1  pixel write enable to VGA adapter
x  out  8  pixel column
y  out  7  pixel row
colour  out  COLOR_W  pixel colour

Behaviour:
- Reset (resetn low, asynchronous, at any time including mid-draw): state IDLE, busy=0, done=0, drawEn=0, x=X0, y=Y0, colour=EMPTY_COLOR, internal column/row counters=0, latched value=0.
- States: IDLE, DRAW, DONE.
- IDLE: on an edge with start=1, latch len = min(value, MAX_LEN), set col=0, row=0, go to DRAW. In that same edge: drawEn=1, busy=1, x=X0, y=Y0, and colour for column 0.
- DRAW: exactly one pixel per cycle, column-major order: row increments 0..BAR_H-1, then column increments and row returns to 0. x = X0+col, y = Y0+row.
- Colour rule: DIR=0 fills when col < len. DIR=1 fills when col >= MAX_LEN-len. Every other pixel is EMPTY_COLOR.
- Pixel count is exactly MAX_LEN*BAR_H. drawEn is continuously high for those cycles with no gaps and no duplicate pixels.
- On the edge after the last pixel (col=MAX_LEN-1, row=BAR_H-1) is presented: drawEn=0, busy=0, done=1, go to DONE. x/y hold their last values.
- DONE: done stays 1 while start=1. No redraw occurs, even if value changes. On an edge with start=0: done=0 and go to IDLE. A new draw requires start to be low for at least one edge and then high again.
- value is ignored outside the start edge. Changes during DRAW or DONE do not affect the current frame.
- start dropping during DRAW does not abort the draw. The draw completes, then done pulses for one cycle, and the block returns to IDLE on the next edge.
- Arithmetic: column counter is clog2(MAX_LEN+1) bits. The clamp comparison is made at the wider of VAL_W and the counter width, so there is no truncation when value > MAX_LEN.
- Latency: start edge to first pixel is 0 cycles (registered on the start edge). Start edge to done = MAX_LEN*BAR_H edges.

Test Plan:
- Defaults, value=10, start held high -> 124 consecutive drawEn cycles. First pixel (128,6) after the start edge, last (158,9). Columns 128..137 FILL, 139..158 EMPTY, 138 EMPTY. done=1 on the 125th edge and held while start is high.
- value=0 -> all 124 pixels EMPTY_COLOR. value=31 -> all FILL. MAX_LEN=20 instance with value=31 -> clamped, all 80 pixels FILL.
- value changed 10->3 at pixel 40, and start dropped at pixel 60 -> frame still matches the value=10 frame. done is high for exactly one cycle, then IDLE.
- resetn low at pixel 50 (between edges) -> drawEn, busy, done drop immediately and x=128, y=6. After release, a start with value=5 draws a complete fresh frame from (128,6).
- After done with start held high for 20 cycles -> no drawEn. Drop start -> done=0 next edge. Raise start with value=7 -> new 124-pixel frame with 7 FILL columns.
- DIR=1, value=10 -> columns 149..158 FILL, 128..148 EMPTY. Scan order and pixel count are unchanged.

Source files
------------

// File: rtl/draw_bar.sv
// Renders a full horizontal gauge (fill + empty columns) into a VGA pixel-write
// port, one pixel per clock, column-major, under a start/done level handshake.
module draw_bar #(
  parameter int                   X0          = 128,
  parameter int                   Y0          = 6,
  parameter int                   BAR_H       = 4,
  parameter int                   MAX_LEN     = 31,
  parameter int                   VAL_W       = 5,
  parameter int                   COLOR_W     = 3,
  parameter logic [COLOR_W-1:0]   FILL_COLOR  = 3'b100,
  parameter logic [COLOR_W-1:0]   EMPTY_COLOR = 3'b000,
  parameter int                   DIR         = 0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [VAL_W-1:0]   value,
  output logic               busy,
  output logic               done,
  output logic               drawEn,
  output logic [7:0]         x,
  output logic [6:0]         y,
  output logic [COLOR_W-1:0] colour
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int RW = (BAR_H > 1) ? $clog2(BAR_H) : 1;
  localparam int MW = (VAL_W > CW) ? VAL_W : CW;

  localparam logic [CW-1:0] MAX_C    = CW'(MAX_LEN);
  localparam logic [CW-1:0] LAST_COL = CW'(MAX_LEN - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(BAR_H - 1);
  localparam logic [MW-1:0] MAX_W    = MW'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t         state;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [CW-1:0]  len;

  logic [MW-1:0]  value_wide;
  logic [CW-1:0]  len_clamped;
  logic           last_row;
  logic           last_pixel;
  logic [CW-1:0]  col_next;
  logic [RW-1:0]  row_next;

  // Fill decision for one column; DIR=1 anchors the filled run at the right end.
  function automatic logic [COLOR_W-1:0] pick_colour(input logic [CW-1:0] c,
                                                     input logic [CW-1:0] l);
    logic fill;
    if (DIR == 0) fill = (c < l);
    else          fill = (c >= (MAX_C - l));
    return fill ? FILL_COLOR : EMPTY_COLOR;
  endfunction

  // Clamp at the wider width so values above MAX_LEN never wrap.
  always_comb begin
    value_wide  = MW'(value);
    len_clamped = (value_wide > MAX_W) ? MAX_C : CW'(value_wide);
  end

  always_comb begin
    last_row   = (row == LAST_ROW);
    last_pixel = last_row && (col == LAST_COL);
    col_next   = last_row ? col + CW'(1) : col;
    row_next   = last_row ? '0 : row + RW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      col    <= '0;
      row    <= '0;
      len    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      drawEn <= 1'b0;
      x      <= 8'(X0);
      y      <= 7'(Y0);
      colour <= EMPTY_COLOR;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_DRAW;
            len    <= len_clamped;
            col    <= '0;
            row    <= '0;
            busy   <= 1'b1;
            drawEn <= 1'b1;
            x      <= 8'(X0);
            y      <= 7'(Y0);
            colour <= pick_colour('0, len_clamped);
          end
        end

        S_DRAW: begin
          if (last_pixel) begin
            // x/y keep the last pixel's coordinates.
            state  <= S_DONE;
            busy   <= 1'b0;
            drawEn <= 1'b0;
            done   <= 1'b1;
          end else begin
            col    <= col_next;
            row    <= row_next;
            x      <= 8'(X0) + 8'(col_next);
            y      <= 7'(Y0) + 7'(row_next);
            colour <= pick_colour(col_next, len);
          end
        end

        S_DONE: begin
          if (!start) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end

        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          drawEn <= 1'b0;
        end
      endcase
    end
  end

endmodule
